// File: rtl/sip_slice_seq.sv
// ============================================================================
//  Module   : sip_slice_seq
//  Brief    : Bit-serial slice sequencer for the SIP dot-product datapath.
//             Optional macro SIP_SEQ_PIPE_EN adds a register stage on i_DotSum.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sip_slice_seq #(
    parameter int BITS_SIP_DOT_ADDER = 10,
    parameter int BITS_ACC           = 24
) (
    input  logic                                 i_CLK,
    input  logic                                 i_RSTn,
    input  logic                                 i_Start,
    output logic                                 o_Ready,
    input  logic [1:0]                           i_PrecA,
    input  logic [1:0]                           i_PrecW,
    input  logic                                 i_SignedA,
    input  logic                                 i_SignedW,
    input  logic                                 i_Abort,
    output logic [1:0]                           o_SliceA,
    output logic [1:0]                           o_SliceW,
    output logic                                 o_SignI,
    output logic                                 o_SignW,
    input  logic signed [BITS_SIP_DOT_ADDER-1:0] i_DotSum,
    output logic signed [BITS_ACC-1:0]           o_Acc,
    output logic                                 o_Valid,
    input  logic                                 i_Ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [1:0]                  last_a_q, last_a_d;
    logic [1:0]                  last_w_q, last_w_d;
    logic                        sgn_a_q, sgn_a_d;
    logic                        sgn_w_q, sgn_w_d;
    logic [1:0]                  slice_a_q, slice_a_d;
    logic [1:0]                  slice_w_q, slice_w_d;
    logic signed [BITS_ACC-1:0]  acc_q, acc_d;

    logic [3:0]                  shamt;
    logic                        last_w_pos;
    logic                        last_pair;
    logic                        run_active;

    // Highest slice index for a precision code; 11 behaves like 8-bit.
    function automatic logic [1:0] prec_last(input logic [1:0] prec);
        case (prec)
            2'b00:   prec_last = 2'd0;
            2'b01:   prec_last = 2'd1;
            default: prec_last = 2'd3;
        endcase
    endfunction

    assign shamt      = {({1'b0, slice_a_q} + {1'b0, slice_w_q}), 1'b0};
    assign last_w_pos = (slice_w_q == last_w_q);
    assign last_pair  = last_w_pos && (slice_a_q == last_a_q);

`ifdef SIP_SEQ_PIPE_EN
    logic signed [BITS_SIP_DOT_ADDER-1:0] pdot_q, pdot_d;
    logic [3:0]                           pshamt_q, pshamt_d;
    logic                                 pvld_q, pvld_d;
    logic                                 drain_q, drain_d;
    logic signed [BITS_ACC-1:0]           pdot_ext;

    assign pdot_ext   = BITS_ACC'(pdot_q);
    assign run_active = (state_q == S_RUN) && !drain_q;
`else
    logic signed [BITS_ACC-1:0]           dot_ext;

    assign dot_ext    = BITS_ACC'(i_DotSum);
    assign run_active = (state_q == S_RUN);
`endif

    assign o_Ready  = (state_q == S_IDLE);
    assign o_Valid  = (state_q == S_DONE);
    assign o_Acc    = acc_q;
    assign o_SliceA = slice_a_q;
    assign o_SliceW = slice_w_q;
    assign o_SignI  = run_active && sgn_a_q && (slice_a_q == last_a_q);
    assign o_SignW  = run_active && sgn_w_q && last_w_pos;

    always_comb begin
        state_d   = state_q;
        last_a_d  = last_a_q;
        last_w_d  = last_w_q;
        sgn_a_d   = sgn_a_q;
        sgn_w_d   = sgn_w_q;
        slice_a_d = slice_a_q;
        slice_w_d = slice_w_q;
        acc_d     = acc_q;
`ifdef SIP_SEQ_PIPE_EN
        pdot_d    = pdot_q;
        pshamt_d  = pshamt_q;
        pvld_d    = 1'b0;
        drain_d   = drain_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_Start && !i_Abort) begin
                    last_a_d  = prec_last(i_PrecA);
                    last_w_d  = prec_last(i_PrecW);
                    sgn_a_d   = i_SignedA;
                    sgn_w_d   = i_SignedW;
                    slice_a_d = 2'd0;
                    slice_w_d = 2'd0;
                    acc_d     = '0;
`ifdef SIP_SEQ_PIPE_EN
                    drain_d   = 1'b0;
`endif
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (i_Abort) begin
                    slice_a_d = 2'd0;
                    slice_w_d = 2'd0;
                    acc_d     = '0;
`ifdef SIP_SEQ_PIPE_EN
                    drain_d   = 1'b0;
`endif
                    state_d   = S_IDLE;
                end else begin
`ifdef SIP_SEQ_PIPE_EN
                    if (pvld_q) begin
                        acc_d = acc_q + (pdot_ext << pshamt_q);
                    end
                    if (drain_q) begin
                        drain_d = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        pdot_d   = i_DotSum;
                        pshamt_d = shamt;
                        pvld_d   = 1'b1;
                        if (last_pair) begin
                            drain_d = 1'b1;
                        end
                    end
`else
                    acc_d = acc_q + (dot_ext << shamt);
                    if (last_pair) begin
                        state_d = S_DONE;
                    end
`endif
                    // Weight slice is the inner loop; both wrap to 0 after the last pair.
                    if (run_active) begin
                        if (last_w_pos) begin
                            slice_w_d = 2'd0;
                            slice_a_d = last_pair ? 2'd0 : slice_a_q + 2'd1;
                        end else begin
                            slice_w_d = slice_w_q + 2'd1;
                        end
                    end
                end
            end
            S_DONE: begin
                if (i_Abort) begin
                    acc_d   = '0;
                    state_d = S_IDLE;
                end else if (i_Ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q   <= S_IDLE;
            last_a_q  <= 2'd0;
            last_w_q  <= 2'd0;
            sgn_a_q   <= 1'b0;
            sgn_w_q   <= 1'b0;
            slice_a_q <= 2'd0;
            slice_w_q <= 2'd0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_a_q  <= last_a_d;
            last_w_q  <= last_w_d;
            sgn_a_q   <= sgn_a_d;
            sgn_w_q   <= sgn_w_d;
            slice_a_q <= slice_a_d;
            slice_w_q <= slice_w_d;
            acc_q     <= acc_d;
        end
    end

`ifdef SIP_SEQ_PIPE_EN
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            pdot_q   <= '0;
            pshamt_q <= 4'd0;
            pvld_q   <= 1'b0;
            drain_q  <= 1'b0;
        end else begin
            pdot_q   <= pdot_d;
            pshamt_q <= pshamt_d;
            pvld_q   <= pvld_d;
            drain_q  <= drain_d;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sip_slice_seq.sv
// ============================================================================
//  Module   : tb_sip_slice_seq
//  Brief    : Table-driven, scoreboarded bench for sip_slice_seq.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sip_slice_seq;

    localparam int BD = 10;
    localparam int BA = 24;
`ifdef SIP_SEQ_PIPE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic                 ready_o;
    logic [1:0]           pa, pw;
    logic                 sa, sw;
    logic                 abort;
    logic [1:0]           slice_a, slice_w;
    logic                 sign_i, sign_w;
    logic signed [BD-1:0] dot;
    logic signed [BA-1:0] acc;
    logic                 valid;
    logic                 rdy_in;

    always #5 clk = ~clk;

    sip_slice_seq #(
        .BITS_SIP_DOT_ADDER(BD),
        .BITS_ACC          (BA)
    ) dut (
        .i_CLK    (clk),
        .i_RSTn   (rst_n),
        .i_Start  (start),
        .o_Ready  (ready_o),
        .i_PrecA  (pa),
        .i_PrecW  (pw),
        .i_SignedA(sa),
        .i_SignedW(sw),
        .i_Abort  (abort),
        .o_SliceA (slice_a),
        .o_SliceW (slice_w),
        .o_SignI  (sign_i),
        .o_SignW  (sign_w),
        .i_DotSum (dot),
        .o_Acc    (acc),
        .o_Valid  (valid),
        .i_Ready  (rdy_in)
    );

    typedef struct {
        logic [1:0] pa;
        logic [1:0] pw;
        logic       sa;
        logic       sw;
        int         dot;
        bit         only_last;
        int         na;
        int         nw;
        int         exp_acc;
        int         hold;
    } vec_t;

    vec_t vecs[7];
    int   exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int idx);
        vec_t v;
        int   n, k, lat, got, expv;
        v    = vecs[idx];
        n    = v.na * v.nw;
        k    = 0;
        expv = 0;
        chk("idle_before_job", ready_o, 1);
        pa     = v.pa;
        pw     = v.pw;
        sa     = v.sa;
        sw     = v.sw;
        dot    = '0;
        rdy_in = 1'b0;
        start  = 1'b1;
        exp_q.push_back(v.exp_acc);
        tick();
        start = 1'b0;
        pa    = ~v.pa;
        pw    = ~v.pw;
        sa    = ~v.sa;
        sw    = ~v.sw;
        lat   = 1;
        while (!valid && lat < 64) begin
            if (k < n) begin
                chk("slice_a", slice_a, k / v.nw);
                chk("slice_w", slice_w, k % v.nw);
                chk("sign_i", sign_i, (v.sa && (k / v.nw == v.na - 1)) ? 1 : 0);
                chk("sign_w", sign_w, (v.sw && (k % v.nw == v.nw - 1)) ? 1 : 0);
                dot = (!v.only_last || k == n - 1) ? BD'(v.dot) : '0;
            end else begin
                chk("drain_signs", {sign_i, sign_w}, 0);
                dot = '0;
            end
            tick();
            lat++;
            k++;
        end
        chk("latency", lat, n + 1 + PIPE);
        if (valid && exp_q.size() > 0) begin
            expv = exp_q.pop_front();
            got  = acc;
            chk("acc_result", got, expv);
        end else begin
            chk("valid_seen", valid, 1);
        end
        for (int h = 0; h < v.hold; h++) begin
            start = 1'b1;
            tick();
            chk("hold_valid", valid, 1);
            chk("hold_acc", acc, expv);
        end
        start  = 1'b0;
        rdy_in = 1'b1;
        tick();
        rdy_in = 1'b0;
        chk("valid_drop", valid, 0);
        chk("back_idle", ready_o, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          pa     pw     sa    sw    dot   last na nw exp       hold
        vecs[0] = '{2'b00, 2'b00, 1'b0, 1'b0,    5, 0,  1, 1,        5, 0};
        vecs[1] = '{2'b01, 2'b01, 1'b0, 1'b0,    1, 0,  2, 2,       25, 3};
        vecs[2] = '{2'b10, 2'b10, 1'b1, 1'b1,   -1, 1,  4, 4,    -4096, 0};
        vecs[3] = '{2'b10, 2'b00, 1'b0, 1'b0,    3, 0,  4, 1,      255, 1};
        vecs[4] = '{2'b11, 2'b01, 1'b0, 1'b0,    1, 0,  4, 2,      425, 0};
        vecs[5] = '{2'b10, 2'b10, 1'b1, 1'b1, -512, 0,  4, 4, -3699200, 0};
        vecs[6] = '{2'b00, 2'b10, 1'b0, 1'b1,   -3, 1,  1, 4,     -192, 0};

        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        rdy_in = 1'b0;
        pa     = 2'b00;
        pw     = 2'b00;
        sa     = 1'b0;
        sw     = 1'b0;
        dot    = '0;
        #12;
        chk("rst_ready", ready_o, 1);
        chk("rst_valid", valid, 0);
        chk("rst_acc", acc, 0);
        chk("rst_slices", {slice_a, slice_w}, 0);
        chk("rst_signs", {sign_i, sign_w}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_job(i);
        end

        // Abort on the second RUN cycle of an 8b x 8b job.
        pa = 2'b10; pw = 2'b10; sa = 1'b0; sw = 1'b0;
        dot = 10'sd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_ready", ready_o, 1);
        chk("abort_valid", valid, 0);
        chk("abort_acc", acc, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_valid", valid, 0);
        end

        // Abort has priority over Start in IDLE.
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_idle_prio", ready_o, 1);
        tick();
        chk("abort_idle_stay", ready_o, 1);

        // Abort while a result is waiting in DONE.
        pa = 2'b00; pw = 2'b00;
        dot = 10'sd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8 && !valid; i++) tick();
        chk("done_reached", valid, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_done_valid", valid, 0);
        chk("abort_done_acc", acc, 0);

        // Asynchronous reset in the middle of a job.
        pa = 2'b10; pw = 2'b10;
        dot = 10'sd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", ready_o, 1);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_acc", acc, 0);
        chk("mid_rst_slices", {slice_a, slice_w}, 0);
        chk("mid_rst_signs", {sign_i, sign_w}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_job(0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
